// File: rtl/dm_ctrl.sv
// dm_ctrl: multi-cycle byte/half/word data memory with req/ack handshake and fixed latency
module dm_ctrl #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata
);
    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    logic [2:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [2:0]            op_q, op_d;
    logic [DEPTH_LOG2+1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           mem_q [WORDS];

    logic                  accept, fire, bad, half, byte_op, sgn, wr_en, c_we;
    logic [2:0]            c_op;
    logic [DEPTH_LOG2+1:0] c_addr;
    logic [31:0]           c_wdata, rd_word, lane, ld, mask, wr_word;
    logic [DEPTH_LOG2-1:0] idx;
    logic [4:0]            shamt;
    logic                  unused;

    assign unused = ^addr[31:DEPTH_LOG2+2];
    assign busy   = cnt_q != 3'd0;
    assign ack    = ack_q;
    assign err    = err_q;
    assign rdata  = rdata_q;

    // Decode the access being completed (latched while busy, live inputs for a same-edge LATENCY=1 access) and form next state
    always_comb begin
        accept  = req && !busy;
        c_we    = busy ? we_q : we;
        c_op    = busy ? op_q : op;
        c_addr  = busy ? addr_q : addr[DEPTH_LOG2+1:0];
        c_wdata = busy ? wdata_q : wdata;
        fire    = busy ? (cnt_q == 3'd1) : (accept && LATENCY == 1);
        idx     = c_addr[DEPTH_LOG2+1:2];
        half    = c_op == 3'd1 || c_op == 3'd2;
        byte_op = c_op == 3'd3 || c_op == 3'd4;
        sgn     = c_op == 3'd1 || c_op == 3'd3;
        bad     = c_op > 3'd4 || (c_op == 3'd0 && c_addr[1:0] != 2'd0) || (half && c_addr[0]);
        shamt   = {c_addr[1:0], 3'b000};
        rd_word = mem_q[idx];
        lane    = rd_word >> shamt;
        ld      = half ? {{16{sgn & lane[15]}}, lane[15:0]} : byte_op ? {{24{sgn & lane[7]}}, lane[7:0]} : rd_word;
        mask    = half ? 32'h0000_FFFF << shamt : byte_op ? 32'h0000_00FF << shamt : 32'hFFFF_FFFF;
        wr_word = (rd_word & ~mask) | ((c_wdata << shamt) & mask);
        wr_en   = fire && c_we && !bad;
        cnt_d   = accept ? CNT_INIT : busy ? cnt_q - 3'd1 : cnt_q;
        we_d    = accept ? we : we_q;
        op_d    = accept ? op : op_q;
        addr_d  = accept ? addr[DEPTH_LOG2+1:0] : addr_q;
        wdata_d = accept ? wdata : wdata_q;
        ack_d   = fire;
        err_d   = fire && bad;
        rdata_d = (fire && !c_we) ? (bad ? 32'd0 : ld) : rdata_q;
    end

    // Control and request registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage array: cleared by reset, written only on an error-free store completion
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[idx] <= wr_word;
        end
    end
endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

Parametrised multi-cycle data memory for the MIPS pipeline's MEM stage, generalising the single-cycle word data memory. It supports word, halfword and byte loads and stores with sign or zero extension, little-endian byte lanes and a configurable depth. A fixed, configurable access latency is presented through a req/ack handshake. Misaligned or illegal accesses are flagged and never modify memory.

## Interface
Parameters:
- DEPTH_LOG2, default 10: log2 of the number of 32-bit words; word index = addr[DEPTH_LOG2+1:2]; higher address bits are ignored.
- LATENCY, default 1: cycles from accept to ack; legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- req  in  1  access request; sampled only when busy=0.
- we  in  1  1 = store, 0 = load; sampled at accept.
- op  in  3  size: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101–111 illegal.
- addr  in  32  byte address; sampled at accept.
- wdata  in  32  store data; sampled at accept.
- busy  out  1  access in flight; req ignored while high.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; 1 = misaligned or illegal op.
- rdata  out  32  load result; updated only on ack of a load, held otherwise.

## Operation
- Accept: req=1 and busy=0 at a rising edge. we, op, addr and wdata are latched into internal registers. Later input changes have no effect.
- Counter: loaded with LATENCY-1 at accept. While nonzero, busy=1 and the counter decrements each cycle. When it reaches zero the access completes.
- Completion edge (LATENCY edges after accept): the array is accessed, ack=1 for exactly one cycle and busy=0. A new req may be accepted in the ack cycle, giving throughput of one access per LATENCY cycles.
- Byte lanes, little-endian: byte addr[1:0]=k occupies bits [8k+7:8k]. A half at addr[1]=h occupies bits [16h+15:16h].
- Stores:
  - word: replaces the whole word.
  - half: wdata[15:0] goes into the selected half.
  - byte: wdata[7:0] goes into the selected lane.
  - Unselected lanes keep their contents.
  - ops 010 and 100 with we=1 behave as 001 and 011.
- Loads: the selected half or byte is sign-extended (001, 011) or zero-extended (010, 100) to 32 bits. A word load is returned unchanged.
- Errors: half with addr[0]=1, word with addr[1:0]≠0, or op ≥ 101.
  - Completes with ack=1, err=1.
  - No array write.
  - rdata is set to 0 for a load.
  - Latency is unchanged.
- Memory contents are 0 at initialisation and after reset.

## Timing
- Reset values: busy=0, ack=0, err=0, rdata=0, counter=0. All words are cleared on the reset edge.
- Reset during an in-flight access aborts it: no write, no ack. reset has priority over req at the same edge.
- LATENCY=1: busy never asserts. The access is accepted at edge T and ack is high in cycle T+1.
- LATENCY=N: busy is high for N-1 cycles after accept, and ack follows in the next cycle.
- err is high only while ack is high; otherwise it is 0.
- Read-after-write: a load accepted in the ack cycle of a store to the same word returns the stored data.
- rdata is unchanged by store acks and by error-free cycles with no ack.

## Test plan
- Reset, then a word load at 0x0: ack after LATENCY cycles, rdata=0x00000000, err=0.
- sw 0x11223344 @0x10, then sb 0xAA @0x11, then lw @0x10: rdata=0x1122AA44. Then lb @0x11 gives 0xFFFFFFAA, and lbu @0x11 gives 0x000000AA.
- sh 0x8001 @0x22, then lh @0x22 gives 0xFFFF8001, and lhu @0x22 gives 0x00008001. The low half of word 0x20 is unchanged.
- LATENCY=3, back-to-back:
  - sw 0xDEADBEEF @0x40, with the next req held high.
  - busy is high for cycles 1–2 and ack is in cycle 3.
  - The lw @0x40 is accepted in the ack cycle and returns 0xDEADBEEF 3 cycles later.
  - A req toggled while busy is ignored.
- Errors:
  - lw @0x42: ack with err=1, rdata=0.
  - sh @0x43: ack with err=1, and a later lw @0x40 is unchanged.
  - op=111: ack with err=1.
- Reset mid-access with LATENCY=4: assert reset 2 cycles after accepting sw 0x5 @0x8. No ack occurs, busy=0, and a later lw @0x8 returns 0.
